agu_station: RTL

AGU_STATION -- requirements
Module: agu_station

---
 rtl/rv32i_types.sv | 15 +
 rtl/agu_select.sv | 23 ++
 rtl/agu_station.sv | 114 +++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared core types: register/queue index widths and the AGU station entry.
package rv32i_types;

  localparam int PHYS_REG_W = 6;
  localparam int MEM_IDX_W  = 6;

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [PHYS_REG_W-1:0] ps1;
    logic [31:0]           imm;
    logic [MEM_IDX_W-1:0]  mem_idx;
  } agu_entry_t;

endpackage

// File: rtl/agu_select.sv
// Lowest-index priority encoder: returns the first set request bit and a found flag.
module agu_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/agu_station.sv
// Address-generation reservation station: holds memory ops until their base
// register is available, then issues one effective address per cycle.
module agu_station
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  input  logic [PHYS_REG_W-1:0] dispatch_ps1,
  input  logic                  dispatch_ps1_ready,
  input  logic [31:0]           dispatch_imm,
  input  logic [MEM_IDX_W-1:0]  dispatch_mem_idx,
  output logic                  full,
  input  logic                  cdb_valid,
  input  logic [PHYS_REG_W-1:0] cdb_pd,
  output logic [PHYS_REG_W-1:0] rs_ps,
  input  logic [31:0]           rs_v,
  output logic [31:0]           addr,
  output logic                  addr_valid,
  output logic [MEM_IDX_W-1:0]  mem_idx_out
);

  localparam int IDX_W = $clog2(DEPTH);

  agu_entry_t           r_ent [DEPTH];
  logic [31:0]          r_addr;
  logic                 r_addr_valid;
  logic [MEM_IDX_W-1:0] r_mem_idx;

  logic [DEPTH-1:0] w_valid_vec;
  logic [DEPTH-1:0] w_issue_req;
  logic [DEPTH-1:0] w_free_req;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_found;
  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_alloc_found;
  logic             w_disp_ready;
  logic             w_do_dispatch;
  logic             w_cdb_hit_disp;

  always_comb begin
    w_valid_vec = '0;
    w_issue_req = '0;
    w_free_req  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i] = r_ent[i].valid;
      w_issue_req[i] = r_ent[i].valid & r_ent[i].ready;
      w_free_req[i]  = ~r_ent[i].valid;
    end
  end

  agu_select #(.N(DEPTH), .IW(IDX_W)) u_issue_sel (
    .i_req  (w_issue_req),
    .o_idx  (w_sel_idx),
    .o_found(w_sel_found)
  );

  agu_select #(.N(DEPTH), .IW(IDX_W)) u_alloc_sel (
    .i_req  (w_free_req),
    .o_idx  (w_alloc_idx),
    .o_found(w_alloc_found)
  );

  // An issuing entry is still valid this cycle, so allocation never picks it.
  assign full           = &w_valid_vec;
  assign w_do_dispatch  = dispatch_valid & ~full & w_alloc_found;
  assign w_cdb_hit_disp = cdb_valid & (cdb_pd == dispatch_ps1);
  assign w_disp_ready   = dispatch_ps1_ready | (dispatch_ps1 == '0) | w_cdb_hit_disp;
  assign rs_ps          = w_sel_found ? r_ent[w_sel_idx].ps1 : '0;

  assign addr        = r_addr;
  assign addr_valid  = r_addr_valid;
  assign mem_idx_out = r_mem_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_mem_idx    <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid <= 1'b0;
        r_ent[i].ready <= 1'b0;
      end
      r_addr_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ent[i].valid && !r_ent[i].ready && cdb_valid && (r_ent[i].ps1 == cdb_pd))
          r_ent[i].ready <= 1'b1;
        if (w_sel_found && (w_sel_idx == IDX_W'(i))) begin
          r_ent[i].valid <= 1'b0;
          r_ent[i].ready <= 1'b0;
        end
        if (w_do_dispatch && (w_alloc_idx == IDX_W'(i))) begin
          r_ent[i].valid   <= 1'b1;
          r_ent[i].ready   <= w_disp_ready;
          r_ent[i].ps1     <= dispatch_ps1;
          r_ent[i].imm     <= dispatch_imm;
          r_ent[i].mem_idx <= dispatch_mem_idx;
        end
      end
      r_addr_valid <= w_sel_found;
      if (w_sel_found) begin
        r_addr    <= rs_v + r_ent[w_sel_idx].imm;
        r_mem_idx <= r_ent[w_sel_idx].mem_idx;
      end
    end
  end

endmodule
